// File: rtl/rv32_decode.sv
// RV32I instruction decode stage.
//
// Takes one fetched instruction per cycle. Register-file read addresses leave
// combinationally in the same cycle; every other decoded field is registered
// so it lines up with the register file's registered operands one cycle later.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   stall_in, flush_in   hold outputs / insert bubble (flush wins over stall)
//   valid_in, instr_in,  fetched instruction and its address
//   pc_in
//   rs1_out, rs2_out     combinational register-file read addresses
//   valid_out ..         registered decode: pc, rd, writeback, immediate, ALU
//   illegal_out          controls, memory controls, branch/jump, illegal flag
module rv32_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rd_out,
  output logic        rd_writeback_out,
  output logic [31:0] imm_out,
  output logic [3:0]  alu_op_out,
  output logic [1:0]  alu_src1_out,
  output logic        alu_src2_imm_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [1:0]  mem_width_out,
  output logic        mem_unsigned_out,
  output logic        branch_out,
  output logic [2:0]  branch_op_out,
  output logic        jump_out,
  output logic        jump_reg_out,
  output logic        illegal_out
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [1:0] Src1Rs1  = 2'd0;
  localparam logic [1:0] Src1Pc   = 2'd1;
  localparam logic [1:0] Src1Zero = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  src1;
    logic        src2_imm;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_width;
    logic        mem_unsigned;
    logic        branch;
    logic [2:0]  branch_op;
    logic        jump;
    logic        jump_reg;
    logic        illegal;
    logic [4:0]  rs1;  // held read addresses, replayed during a stall
    logic [4:0]  rs2;
  } dec_t;

  dec_t dec_d, dec_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        wb, ill;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                  instr_in[11:8], 1'b0};
  assign imm_u = {instr_in[31:12], 12'b0};
  assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                  instr_in[30:21], 1'b0};

  // alt selects SUB/SRA; the caller decides when funct7[5] is meaningful.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? 4'd1 : 4'd0;
      3'b001:  alu_from_f3 = 4'd2;
      3'b010:  alu_from_f3 = 4'd3;
      3'b011:  alu_from_f3 = 4'd4;
      3'b100:  alu_from_f3 = 4'd5;
      3'b101:  alu_from_f3 = alt ? 4'd7 : 4'd6;
      3'b110:  alu_from_f3 = 4'd8;
      default: alu_from_f3 = 4'd9;
    endcase
  endfunction

  always_comb begin
    dec_d       = '0;
    dec_d.valid = 1'b1;
    dec_d.pc    = pc_in;
    dec_d.rd    = instr_in[11:7];
    dec_d.rs1   = instr_in[19:15];
    dec_d.rs2   = instr_in[24:20];
    wb          = 1'b0;
    ill         = 1'b0;
    case (opcode)
      OpLui: begin
        dec_d.src1 = Src1Zero; dec_d.imm = imm_u; dec_d.src2_imm = 1'b1; wb = 1'b1;
      end
      OpAuipc: begin
        dec_d.src1 = Src1Pc; dec_d.imm = imm_u; dec_d.src2_imm = 1'b1; wb = 1'b1;
      end
      OpJal: begin
        dec_d.src1 = Src1Pc; dec_d.imm = imm_j; dec_d.src2_imm = 1'b1;
        dec_d.jump = 1'b1; wb = 1'b1;
      end
      OpJalr: begin
        dec_d.src1 = Src1Rs1; dec_d.imm = imm_i; dec_d.src2_imm = 1'b1;
        dec_d.jump = 1'b1; dec_d.jump_reg = 1'b1; wb = 1'b1;
        ill = (funct3 != 3'b000);
      end
      OpBranch: begin
        dec_d.imm = imm_b; dec_d.branch = 1'b1; dec_d.branch_op = funct3;
        ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OpLoad: begin
        dec_d.imm = imm_i; dec_d.src2_imm = 1'b1; dec_d.mem_read = 1'b1;
        dec_d.mem_width = funct3[1:0]; dec_d.mem_unsigned = funct3[2]; wb = 1'b1;
        ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OpStore: begin
        dec_d.imm = imm_s; dec_d.src2_imm = 1'b1; dec_d.mem_write = 1'b1;
        dec_d.mem_width = funct3[1:0];
        ill = (funct3 >= 3'b011);
      end
      OpImm: begin
        dec_d.imm = imm_i; dec_d.src2_imm = 1'b1; wb = 1'b1;
        // funct7[5] only means SRAI for funct3=101; for ADDI it is immediate data.
        dec_d.alu_op = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001) ill = (funct7 != 7'h00);
        if (funct3 == 3'b101) ill = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OpReg: begin
        wb = 1'b1;
        dec_d.alu_op = alu_from_f3(funct3, funct7[5]);
        ill = !((funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OpFence: ;
      OpSystem: ill = (instr_in != 32'h0000_0073) && (instr_in != 32'h0010_0073);
      default:  ill = 1'b1;
    endcase
    if (instr_in[1:0] != 2'b11) ill = 1'b1;
    // Illegal instructions reach trap logic with no side effects.
    if (ill) begin
      wb              = 1'b0;
      dec_d.mem_read  = 1'b0;
      dec_d.mem_write = 1'b0;
      dec_d.branch    = 1'b0;
      dec_d.jump      = 1'b0;
      dec_d.jump_reg  = 1'b0;
    end
    dec_d.illegal = ill;
    dec_d.wb      = wb && (dec_d.rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q <= '0;
    end else if (flush_in) begin
      dec_q <= '0;
    end else if (!stall_in) begin
      dec_q <= valid_in ? dec_d : '0;
    end
  end

  // During a stall, keep re-reading the held instruction's operands.
  assign rs1_out = stall_in ? dec_q.rs1 : instr_in[19:15];
  assign rs2_out = stall_in ? dec_q.rs2 : instr_in[24:20];

  assign valid_out        = dec_q.valid;
  assign pc_out           = dec_q.pc;
  assign rd_out           = dec_q.rd;
  assign rd_writeback_out = dec_q.wb;
  assign imm_out          = dec_q.imm;
  assign alu_op_out       = dec_q.alu_op;
  assign alu_src1_out     = dec_q.src1;
  assign alu_src2_imm_out = dec_q.src2_imm;
  assign mem_read_out     = dec_q.mem_read;
  assign mem_write_out    = dec_q.mem_write;
  assign mem_width_out    = dec_q.mem_width;
  assign mem_unsigned_out = dec_q.mem_unsigned;
  assign branch_out       = dec_q.branch;
  assign branch_op_out    = dec_q.branch_op;
  assign jump_out         = dec_q.jump;
  assign jump_reg_out     = dec_q.jump_reg;
  assign illegal_out      = dec_q.illegal;

endmodule

// File: tb/tb_rv32_decode.sv
module tb_rv32_decode;

  logic        clk = 1'b0;
  logic        reset, stall_in, flush_in, valid_in;
  logic [31:0] instr_in, pc_in;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic        valid_out, rd_writeback_out, alu_src2_imm_out, mem_read_out, mem_write_out;
  logic        mem_unsigned_out, branch_out, jump_out, jump_reg_out, illegal_out;
  logic [31:0] pc_out, imm_out;
  logic [3:0]  alu_op_out;
  logic [1:0]  alu_src1_out, mem_width_out;
  logic [2:0]  branch_op_out;

  always #5 clk = ~clk;

  rv32_decode dut (
    .clk              (clk),
    .reset            (reset),
    .stall_in         (stall_in),
    .flush_in         (flush_in),
    .valid_in         (valid_in),
    .instr_in         (instr_in),
    .pc_in            (pc_in),
    .rs1_out          (rs1_out),
    .rs2_out          (rs2_out),
    .valid_out        (valid_out),
    .pc_out           (pc_out),
    .rd_out           (rd_out),
    .rd_writeback_out (rd_writeback_out),
    .imm_out          (imm_out),
    .alu_op_out       (alu_op_out),
    .alu_src1_out     (alu_src1_out),
    .alu_src2_imm_out (alu_src2_imm_out),
    .mem_read_out     (mem_read_out),
    .mem_write_out    (mem_write_out),
    .mem_width_out    (mem_width_out),
    .mem_unsigned_out (mem_unsigned_out),
    .branch_out       (branch_out),
    .branch_op_out    (branch_op_out),
    .jump_out         (jump_out),
    .jump_reg_out     (jump_reg_out),
    .illegal_out      (illegal_out)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2;
    logic        ill;
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  src1;
    logic        s2i, mr, mw;
    logic [1:0]  mwid;
    logic        mu, br;
    logic [2:0]  bop;
    logic        j, jr;
  } vec_t;

  localparam int NumVec = 21;
  vec_t vecs [NumVec];

  logic [89:0] act;
  assign act = {valid_out, pc_out, rd_out, rd_writeback_out, imm_out, alu_op_out,
                alu_src1_out, alu_src2_imm_out, mem_read_out, mem_write_out, mem_width_out,
                mem_unsigned_out, branch_out, branch_op_out, jump_out, jump_reg_out,
                illegal_out};

  localparam logic [89:0] FullMask = {90{1'b1}};
  // Illegal: only valid, pc, illegal and the side-effect flags are defined.
  localparam logic [89:0] IllMask = {1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'd0, 4'd0, 2'd0,
                                     1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0,
                                     1'b1};

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [89:0] pack(input logic [31:0] pc, input vec_t e);
    return {1'b1, pc, e.rd, e.wb, e.imm, e.alu, e.src1, e.s2i, e.mr, e.mw, e.mwid, e.mu,
            e.br, e.bop, e.j, e.jr, e.ill};
  endfunction

  task automatic chk(input string name, input logic [89:0] exp, input logic [89:0] mask);
    n_checks++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: outputs %h, expected %h", name, act & mask, exp & mask);
    end
  endtask

  task automatic chk_rs(input string name, input logic [4:0] e1, input logic [4:0] e2);
    n_checks++;
    if (rs1_out !== e1 || rs2_out !== e2) begin
      n_fail++;
      $display("FAIL %s: rs1/rs2 = %0d/%0d, expected %0d/%0d", name, rs1_out, rs2_out, e1, e2);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction, check read addresses now and the decode next cycle.
  task automatic run_vec(input string name, input vec_t v, input logic [31:0] pc);
    instr_in = v.instr;
    pc_in    = pc;
    valid_in = 1'b1;
    #1;
    chk_rs({name, "_rs"}, v.rs1, v.rs2);
    step();
    chk(name, pack(pc, v), v.ill ? IllMask : FullMask);
  endtask

  initial begin
    //         instr         rs1 rs2 ill rd  wb imm           alu src1 s2i mr mw wid mu br bop j jr
    vecs[0]  = '{32'hFFD08293, 5'd1, 5'd29, 1'b0, 5'd5, 1'b1, 32'hFFFFFFFD, 4'd0, 2'd0,
                 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // addi x5,x1,-3
    vecs[1]  = '{32'hFE310CE3, 5'd2, 5'd3, 1'b0, 5'd25, 1'b0, 32'hFFFFFFF8, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};  // beq x2,x3,-8
    vecs[2]  = '{32'h002083B3, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 32'h0, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // add x7,x1,x2
    vecs[3]  = '{32'h405201B3, 5'd4, 5'd5, 1'b0, 5'd3, 1'b1, 32'h0, 4'd1, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // sub x3,x4,x5
    vecs[4]  = '{32'h4020F1B3, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 32'h0, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // OP f7=20 f3=7
    vecs[5]  = '{32'h00000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // all zero
    vecs[6]  = '{32'h12345537, 5'd8, 5'd3, 1'b0, 5'd10, 1'b1, 32'h12345000, 4'd0, 2'd2,
                 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // lui x10
    vecs[7]  = '{32'hFFFFF097, 5'd31, 5'd31, 1'b0, 5'd1, 1'b1, 32'hFFFFF000, 4'd0, 2'd1,
                 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // auipc x1
    vecs[8]  = '{32'h0080006F, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 32'h8, 4'd0, 2'd1,
                 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};  // jal x0,+8
    vecs[9]  = '{32'h004280E7, 5'd5, 5'd4, 1'b0, 5'd1, 1'b1, 32'h4, 4'd0, 2'd0,
                 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};  // jalr x1,4(x5)
    vecs[10] = '{32'hFFF15303, 5'd2, 5'd31, 1'b0, 5'd6, 1'b1, 32'hFFFFFFFF, 4'd0, 2'd0,
                 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};  // lhu x6,-1(x2)
    vecs[11] = '{32'h00512623, 5'd2, 5'd5, 1'b0, 5'd12, 1'b0, 32'hC, 4'd0, 2'd0,
                 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // sw x5,12(x2)
    vecs[12] = '{32'h40325213, 5'd4, 5'd3, 1'b0, 5'd4, 1'b1, 32'h403, 4'd7, 2'd0,
                 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // srai x4,x4,3
    vecs[13] = '{32'h40321213, 5'd4, 5'd3, 1'b1, 5'd0, 1'b0, 32'h0, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // slli f7=20
    vecs[14] = '{32'h00000073, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // ecall
    vecs[15] = '{32'h00100073, 5'd0, 5'd1, 1'b0, 5'd0, 1'b0, 32'h0, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // ebreak
    vecs[16] = '{32'h0FF0000F, 5'd0, 5'd31, 1'b0, 5'd0, 1'b0, 32'h0, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // fence
    vecs[17] = '{32'h00008291, 5'd1, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // low bits 01
    vecs[18] = '{32'h0020A063, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 32'h0, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // branch f3=010
    vecs[19] = '{32'h00A4B433, 5'd9, 5'd10, 1'b0, 5'd8, 1'b1, 32'h0, 4'd4, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};  // sltu x8,x9,x10
    vecs[20] = '{32'h0020D863, 5'd1, 5'd2, 1'b0, 5'd16, 1'b0, 32'h10, 4'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0};  // bge x1,x2,+16

    reset    = 1'b1;
    stall_in = 1'b0;
    flush_in = 1'b0;
    valid_in = 1'b1;
    instr_in = 32'hFFD08293;
    pc_in    = 32'h100;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("reset_c%0d", c), '0, FullMask);
    end
    reset = 1'b0;

    // Vector 0 is applied immediately, so its decode is the first after reset.
    for (int i = 0; i < NumVec; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], 32'h100 + 32'(4 * i));
    end

    // Stall: add held for three cycles while fetch presents junk.
    run_vec("stall_pre", vecs[2], 32'h200);
    stall_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      instr_in = $urandom;
      pc_in    = $urandom;
      #1;
      chk_rs($sformatf("stall_rs_c%0d", c), 5'd1, 5'd2);
      step();
      chk($sformatf("stall_hold_c%0d", c), pack(32'h200, vecs[2]), FullMask);
    end
    stall_in = 1'b0;
    run_vec("stall_release", vecs[3], 32'h204);

    // Flush and stall together on a valid lw x1,0(x2).
    run_vec("flush_pre", vecs[0], 32'h300);
    flush_in = 1'b1;
    stall_in = 1'b1;
    instr_in = 32'h00012083;
    pc_in    = 32'h304;
    step();
    chk("flush_stall_bubble", '0, FullMask);
    flush_in = 1'b0;
    stall_in = 1'b0;

    // valid_in low gives a bubble.
    valid_in = 1'b0;
    instr_in = vecs[2].instr;
    step();
    chk("invalid_bubble", '0, FullMask);
    run_vec("post_bubble", vecs[19], 32'h308);

    // Reset mid-stream dominates a concurrent stall and clears held addresses.
    run_vec("reset_pre", vecs[0], 32'h400);
    reset    = 1'b1;
    stall_in = 1'b1;
    step();
    chk("reset_mid", '0, FullMask);
    chk_rs("reset_mid_rs", 5'd0, 5'd0);
    reset    = 1'b0;
    stall_in = 1'b0;
    run_vec("post_reset", vecs[12], 32'h404);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
